// File: rtl/icache_pkg.sv
// Shared widths and the refill FSM state type for the icache data-array controller.
package icache_pkg;

   localparam int ICACHE_LINE_WIDTH = 256;
   localparam int ICACHE_BEAT_WIDTH = 64;
   localparam int ICACHE_IDX_WIDTH  = 4;
   localparam int ICACHE_NUM_WMASKS = ICACHE_LINE_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DRAIN1,
      DRAIN2
   } fill_state_t;

endpackage

// File: rtl/icache_wmask_gen.sv
// Byte write mask for refill beat number beat_cnt: one beat-wide run of ones
// positioned over the bytes that beat occupies within the line.
module icache_wmask_gen #(
   parameter int NUM_WMASKS = 32,
   parameter int BEAT_BYTES = 8,
   parameter int CNT_W      = 2
) (
   input  logic [CNT_W-1:0]      beat_cnt,
   output logic [NUM_WMASKS-1:0] wmask
);

   localparam logic [NUM_WMASKS-1:0] BASE_MASK =
      {{(NUM_WMASKS-BEAT_BYTES){1'b0}}, {BEAT_BYTES{1'b1}}};

   // Shift the base run up by one beat per count.
   always_comb begin
      wmask = BASE_MASK << (32'(beat_cnt) * BEAT_BYTES);
   end

endmodule

// File: rtl/icache_data_fill_ctrl.sv
// Refill writer and CPU line reader for the icache data-array SRAM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | ready for a refill request; latches the line index
//   COLLECT | accepting beats, each one registered as a masked write
//   DRAIN1  | last write being captured by the SRAM
//   DRAIN2  | last write committing; fill_done fires on the way to IDLE
//
// Reads of the line being refilled are held off until the FSM is back in IDLE,
// which is only after the final beat has committed in the array.
module icache_data_fill_ctrl
   import icache_pkg::*;
#(
   parameter int ADDR_WIDTH = ICACHE_IDX_WIDTH,
   parameter int LINE_WIDTH = ICACHE_LINE_WIDTH,
   parameter int BEAT_WIDTH = ICACHE_BEAT_WIDTH,
   parameter int NUM_WMASKS = ICACHE_NUM_WMASKS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fill_valid,
   input  logic [ADDR_WIDTH-1:0] fill_idx,
   output logic                  fill_ready,
   input  logic                  beat_valid,
   input  logic [BEAT_WIDTH-1:0] beat_data,
   output logic                  beat_ready,
   output logic                  fill_done,
   input  logic                  rd_valid,
   input  logic [ADDR_WIDTH-1:0] rd_idx,
   output logic                  rd_ready,
   output logic                  rd_resp_valid,
   output logic [LINE_WIDTH-1:0] rd_resp_data,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [LINE_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [LINE_WIDTH-1:0] sram_dout1
);

   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   fill_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] fill_idx_q, fill_idx_d;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic                  csb0_q, csb0_d;
   logic                  web0_q, web0_d;
   logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
   logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
   logic [LINE_WIDTH-1:0] din0_q, din0_d;
   logic                  fill_done_q, fill_done_d;
   logic                  rd_resp_valid_q, rd_resp_valid_d;
   logic [NUM_WMASKS-1:0] beat_wmask;
   logic                  rd_accept;

   icache_wmask_gen #(
      .NUM_WMASKS (NUM_WMASKS),
      .BEAT_BYTES (BEAT_WIDTH / 8),
      .CNT_W      (CNT_W)
   ) u_wmask_gen (
      .beat_cnt (beat_cnt_q),
      .wmask    (beat_wmask)
   );

   // State, beat counter, port-0 drive and response flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         fill_idx_q      <= '0;
         beat_cnt_q      <= '0;
         csb0_q          <= 1'b1;
         web0_q          <= 1'b1;
         wmask0_q        <= '0;
         addr0_q         <= '0;
         din0_q          <= '0;
         fill_done_q     <= 1'b0;
         rd_resp_valid_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         fill_idx_q      <= fill_idx_d;
         beat_cnt_q      <= beat_cnt_d;
         csb0_q          <= csb0_d;
         web0_q          <= web0_d;
         wmask0_q        <= wmask0_d;
         addr0_q         <= addr0_d;
         din0_q          <= din0_d;
         fill_done_q     <= fill_done_d;
         rd_resp_valid_q <= rd_resp_valid_d;
      end
   end

   // Refill sequencing: next state, handshakes and the next port-0 write.
   always_comb begin
      state_d     = state_q;
      fill_idx_d  = fill_idx_q;
      beat_cnt_d  = beat_cnt_q;
      csb0_d      = 1'b1;
      web0_d      = 1'b1;
      wmask0_d    = wmask0_q;
      addr0_d     = addr0_q;
      din0_d      = din0_q;
      fill_done_d = 1'b0;
      fill_ready  = 1'b0;
      beat_ready  = 1'b0;
      case (state_q)
         IDLE: begin
            fill_ready = 1'b1;
            beat_cnt_d = '0;
            if (fill_valid) begin
               fill_idx_d = fill_idx;
               state_d    = COLLECT;
            end
         end
         COLLECT: begin
            beat_ready = 1'b1;
            if (beat_valid) begin
               csb0_d     = 1'b0;
               web0_d     = 1'b0;
               addr0_d    = fill_idx_q;
               wmask0_d   = beat_wmask;
               din0_d     = {BEATS{beat_data}};
               beat_cnt_d = beat_cnt_q + CNT_W'(1);
               if (beat_cnt_q == LAST_BEAT) begin
                  state_d = DRAIN1;
               end
            end
         end
         DRAIN1: begin
            state_d = DRAIN2;
         end
         DRAIN2: begin
            state_d     = IDLE;
            fill_done_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Read port: stall only the line under refill; address passes straight through.
   always_comb begin
      rd_ready        = !((state_q != IDLE) && (rd_idx == fill_idx_q));
      rd_accept       = rd_valid && rd_ready;
      sram_csb1       = !rd_accept;
      sram_addr1      = rd_idx;
      rd_resp_valid_d = rd_accept;
   end

   assign fill_done     = fill_done_q;
   assign rd_resp_valid = rd_resp_valid_q;
   assign rd_resp_data  = rd_resp_valid_q ? sram_dout1 : '0;
   assign sram_csb0     = csb0_q;
   assign sram_web0     = web0_q;
   assign sram_wmask0   = wmask0_q;
   assign sram_addr0    = addr0_q;
   assign sram_din0     = din0_q;

endmodule
